// File: rtl/kyber_encode_pkg.sv
// Shared definitions for the Kyber ByteEncode serializer: buffer sizing,
// FSM state type and frame-length helper.
package kyber_encode_pkg;

    localparam int ELL_MAX = 12;
    localparam int BUF_W   = 24;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

    function automatic int bytes_per_frame(input int ell, input int n);
        return (n * ell) / 8;
    endfunction

endpackage

// File: rtl/byte_encode.sv
// Streaming Kyber ByteEncode_ELL: packs ELL-bit coefficients little-endian
// into a byte stream with valid/ready handshakes on both sides.
module byte_encode
    import kyber_encode_pkg::*;
#(
    parameter int ELL        = 12,
    parameter int NUM_COEFFS = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [ELL-1:0] in_coeff,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_byte,
    output logic           out_last,
    output logic           busy,
    output logic           done
);

    localparam int NBYTES = bytes_per_frame(ELL, NUM_COEFFS);
    localparam int CCW    = $clog2(NUM_COEFFS + 1);
    localparam int BCW    = $clog2(NBYTES + 1);

    if ((ELL < 1) || (ELL > ELL_MAX)) begin : g_bad_ell
        $error("byte_encode: ELL out of range 1..12");
    end
    if (((NUM_COEFFS * ELL) % 8) != 0) begin : g_bad_frame
        $error("byte_encode: NUM_COEFFS*ELL must be a multiple of 8");
    end

    enc_state_t       state_r;
    enc_state_t       state_s;
    logic [BUF_W-1:0] buf_r;
    logic [4:0]       cnt_r;
    logic [CCW-1:0]   coeff_cnt_r;
    logic [BCW-1:0]   byte_cnt_r;
    logic             done_r;
    logic             run_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [BUF_W-1:0] coeff_ext_s;

    // Outputs derive only from registered state, so no path from in_* or out_ready.
    assign run_s       = (state_r == RUN);
    assign in_ready    = run_s && (cnt_r < 5'd8) && (coeff_cnt_r < CCW'(NUM_COEFFS));
    assign out_valid   = run_s && (cnt_r >= 5'd8);
    assign out_byte    = buf_r[7:0];
    assign out_last    = out_valid && (byte_cnt_r == BCW'(NBYTES - 1));
    assign busy        = run_s;
    assign done        = done_r;
    assign in_fire_s   = in_valid && in_ready;
    assign out_fire_s  = out_valid && out_ready;
    assign coeff_ext_s = BUF_W'(in_coeff);

    // Next-state logic for the IDLE/RUN frame controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (out_fire_s && out_last) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bit buffer, counters and done pulse; accept and emit never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_r       <= '0;
            cnt_r       <= 5'd0;
            coeff_cnt_r <= '0;
            byte_cnt_r  <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= run_s && out_fire_s && out_last;
            if (!run_s) begin
                if (start) begin
                    buf_r       <= '0;
                    cnt_r       <= 5'd0;
                    coeff_cnt_r <= '0;
                    byte_cnt_r  <= '0;
                end
            end else if (in_fire_s) begin
                buf_r       <= buf_r | (coeff_ext_s << cnt_r);
                cnt_r       <= cnt_r + 5'(ELL);
                coeff_cnt_r <= coeff_cnt_r + CCW'(1);
            end else if (out_fire_s) begin
                buf_r      <= buf_r >> 8;
                cnt_r      <= cnt_r - 5'd8;
                byte_cnt_r <= byte_cnt_r + BCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_byte_encode.sv
// Randomized self-checking bench for byte_encode: several parameterizations
// driven one at a time and compared against a bit-list packing model.
module tb_byte_encode;

    localparam int NINST = 5;

    function automatic int ell_of(input int k);
        case (k)
            0: return 12;
            1: return 1;
            2: return 4;
            3: return 10;
            default: return 12;
        endcase
    endfunction

    function automatic int n_of(input int k);
        case (k)
            0: return 2;
            1: return 8;
            2: return 256;
            default: return 64;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a     [NINST];
    logic        in_valid_a  [NINST];
    logic [11:0] coeff_a     [NINST];
    logic        out_ready_a [NINST];
    logic        in_ready_a  [NINST];
    logic        out_valid_a [NINST];
    logic [7:0]  out_byte_a  [NINST];
    logic        out_last_a  [NINST];
    logic        busy_a      [NINST];
    logic        done_a      [NINST];

    int nvec = 0;
    int nerr = 0;
    logic [11:0] cq[$];
    logic [7:0]  eq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        localparam int E = ell_of(g);
        byte_encode #(.ELL(E), .NUM_COEFFS(n_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_a[g]),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_coeff  (coeff_a[g][E-1:0]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_byte  (out_byte_a[g]),
            .out_last  (out_last_a[g]),
            .busy      (busy_a[g]),
            .done      (done_a[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference packing: flatten coefficients to a bit list, then cut into bytes.
    task automatic build_exp(input int n, input int ell);
        bit bits[$];
        logic [7:0] v;
        eq.delete();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < ell; j++)
                bits.push_back(cq[i][j]);
        for (int b = 0; b < (n * ell) / 8; b++) begin
            for (int j = 0; j < 8; j++) v[j] = bits[8 * b + j];
            eq.push_back(v);
        end
    endtask

    task automatic check_reset(input int k);
        check("rst_in_ready",  in_ready_a[k],  0);
        check("rst_out_valid", out_valid_a[k], 0);
        check("rst_out_byte",  out_byte_a[k],  0);
        check("rst_out_last",  out_last_a[k],  0);
        check("rst_busy",      busy_a[k],      0);
        check("rst_done",      done_a[k],      0);
    endtask

    task automatic random_coeffs(input int n, input int ell);
        cq.delete();
        for (int i = 0; i < n; i++) cq.push_back(12'($urandom_range(0, (1 << ell) - 1)));
    endtask

    task automatic run_frame(input int k, input int n, input int ell, input int abort_at,
                             input bit bp, input bit poke);
        int ci = 0;
        int bi = 0;
        int cyc = 0;
        int nb = (n * ell) / 8;
        int limit = 20 * n * ell + 200;
        bit stalled = 1'b0;
        bit aborted = 1'b0;
        bit rdy;
        bit vld;
        logic [7:0] prev = 8'h00;
        logic iv, ov, ol;
        logic [7:0] ob;
        @(negedge clk);
        start_a[k] = 1'b1;
        @(negedge clk);
        start_a[k] = 1'b0;
        check("start_busy", busy_a[k], 1);
        check("start_in_ready", in_ready_a[k], 1);
        while (bi < nb) begin
            if ((abort_at > 0) && (ci >= abort_at)) begin
                aborted = 1'b1;
                break;
            end
            if (cyc > limit) begin
                check("timeout", 1, 0);
                break;
            end
            iv = in_ready_a[k];
            ov = out_valid_a[k];
            ol = out_last_a[k];
            ob = out_byte_a[k];
            check("excl", iv & ov, 0);
            check("busy", busy_a[k], 1);
            check("last", ol, ov && (bi == nb - 1));
            if (ci == n) check("in_ready_end", iv, 0);
            if (stalled) begin
                check("stall_valid", ov, 1);
                check("stall_byte", ob, prev);
            end
            rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready_a[k] = rdy;
            if (ov && rdy) begin
                check("byte", ob, eq[bi]);
                bi++;
            end
            stalled = ov && !rdy;
            prev = ob;
            vld = (ci < n) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_valid_a[k] = vld;
            coeff_a[k] = vld ? cq[ci] : 12'h000;
            if (iv && vld) ci++;
            start_a[k] = poke && (cyc == 3);
            cyc++;
            @(negedge clk);
        end
        in_valid_a[k] = 1'b0;
        start_a[k] = 1'b0;
        if (!aborted) begin
            check("end_busy", busy_a[k], 0);
            check("end_done", done_a[k], 1);
            check("end_valid", out_valid_a[k], 0);
            @(negedge clk);
            check("done_drop", done_a[k], 0);
        end
    endtask

    initial begin
        for (int k = 0; k < NINST; k++) begin
            start_a[k] = 1'b0;
            in_valid_a[k] = 1'b0;
            coeff_a[k] = 12'h000;
            out_ready_a[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NINST; k++) check_reset(k);
        rst = 1'b0;

        cq = '{12'h123, 12'h456};
        eq = '{8'h23, 8'h61, 8'h45};
        run_frame(0, 2, 12, 0, 1'b0, 1'b0);

        cq = '{12'd1, 12'd0, 12'd1, 12'd1, 12'd0, 12'd0, 12'd0, 12'd1};
        eq = '{8'h8D};
        run_frame(1, 8, 1, 0, 1'b0, 1'b0);

        cq.delete();
        eq.delete();
        for (int i = 0; i < 256; i++) cq.push_back(12'(i % 16));
        for (int b = 0; b < 128; b++) eq.push_back(8'((((2 * b + 1) % 16) << 4) | ((2 * b) % 16)));
        run_frame(2, 256, 4, 0, 1'b0, 1'b0);

        for (int r = 0; r < 2; r++) begin
            random_coeffs(64, 10);
            build_exp(64, 10);
            run_frame(3, 64, 10, 0, 1'b1, 1'b0);
        end

        random_coeffs(64, 12);
        build_exp(64, 12);
        run_frame(4, 64, 12, 37, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset(4);
        rst = 1'b0;
        random_coeffs(64, 12);
        build_exp(64, 12);
        run_frame(4, 64, 12, 0, 1'b1, 1'b0);

        in_valid_a[4] = 1'b1;
        coeff_a[4] = 12'hFFF;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", in_ready_a[4], 0);
            check("idle_out_valid", out_valid_a[4], 0);
            check("idle_busy", busy_a[4], 0);
        end
        in_valid_a[4] = 1'b0;
        random_coeffs(64, 12);
        build_exp(64, 12);
        run_frame(4, 64, 12, 0, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("post_valid", out_valid_a[4], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
